// File: rtl/rob_retire_if.sv
// Rename/execute <-> ROB handshake bundle: allocation, completion, retire and free-list return.
interface rob_retire_if #(
    parameter int PREG_NUM = 64,
    parameter int PTAG_W   = 6,
    parameter int IDX_W    = 4
);
    logic                alloc_valid_1;
    logic                alloc_has_rd_1;
    logic [PTAG_W-1:0]   alloc_newrd_1;
    logic [PTAG_W-1:0]   alloc_oldrd_1;
    logic                alloc_valid_2;
    logic                alloc_has_rd_2;
    logic [PTAG_W-1:0]   alloc_newrd_2;
    logic [PTAG_W-1:0]   alloc_oldrd_2;
    logic                alloc_ready;
    logic [IDX_W-1:0]    alloc_idx_1;
    logic [IDX_W-1:0]    alloc_idx_2;
    logic                complete_valid_a;
    logic [IDX_W-1:0]    complete_idx_a;
    logic                complete_valid_b;
    logic [IDX_W-1:0]    complete_idx_b;
    logic                retire_valid_1;
    logic [PTAG_W-1:0]   retire_newrd_1;
    logic                retire_valid_2;
    logic [PTAG_W-1:0]   retire_newrd_2;
    logic [PREG_NUM-1:0] free_regs;
    logic [IDX_W:0]      rob_count;

    // rename/execute side
    modport master (
        output alloc_valid_1, alloc_has_rd_1, alloc_newrd_1, alloc_oldrd_1,
        output alloc_valid_2, alloc_has_rd_2, alloc_newrd_2, alloc_oldrd_2,
        output complete_valid_a, complete_idx_a, complete_valid_b, complete_idx_b,
        input  alloc_ready, alloc_idx_1, alloc_idx_2,
        input  retire_valid_1, retire_newrd_1, retire_valid_2, retire_newrd_2,
        input  free_regs, rob_count
    );

    // ROB side
    modport slave (
        input  alloc_valid_1, alloc_has_rd_1, alloc_newrd_1, alloc_oldrd_1,
        input  alloc_valid_2, alloc_has_rd_2, alloc_newrd_2, alloc_oldrd_2,
        input  complete_valid_a, complete_idx_a, complete_valid_b, complete_idx_b,
        output alloc_ready, alloc_idx_1, alloc_idx_2,
        output retire_valid_1, retire_newrd_1, retire_valid_2, retire_newrd_2,
        output free_regs, rob_count
    );
endinterface

// File: rtl/rob_retire.sv
// 2-wide in-order reorder buffer / retire unit. Returns the old physical
// mapping of each retired writer to rename as a one-hot free_regs pulse.

// One retire lane: fires only if every older lane fired and its entry is done.
module rob_retire_lane #(
    parameter int PREG_NUM = 64,
    parameter int PTAG_W   = 6
) (
    input  logic                prev_fire,
    input  logic                ent_valid,
    input  logic                ent_done,
    input  logic                ent_has_rd,
    input  logic [PTAG_W-1:0]   ent_oldrd,
    output logic                fire,
    output logic [PREG_NUM-1:0] mask
);
    assign fire = prev_fire & ent_valid & ent_done;

    // p0 is the hardwired zero register and must never re-enter the free pool
    always_comb begin
        mask = '0;
        if (fire && ent_has_rd && ent_oldrd != '0)
            mask[ent_oldrd] = 1'b1;
    end
endmodule

module rob_retire #(
    parameter int ROB_DEPTH = 16,
    parameter int PREG_NUM  = 64,
    parameter int PTAG_W    = 6,
    parameter int IDX_W     = 4
) (
    input  logic   clk,
    input  logic   reset,
    rob_retire_if.slave rob
);
    localparam int             LANES     = 2;
    localparam logic [IDX_W:0] READY_MAX = (IDX_W+1)'(ROB_DEPTH - LANES);

    // head/tail carry a wrap bit so a full ROB is distinguishable from empty
    logic [IDX_W:0]         head, tail, count, head_nxt, tail_nxt;
    logic [ROB_DEPTH-1:0]   ent_valid, ent_done;
    logic                   ent_has_rd [ROB_DEPTH];
    logic [PTAG_W-1:0]      ent_newrd  [ROB_DEPTH];
    logic [PTAG_W-1:0]      ent_oldrd  [ROB_DEPTH];

    logic                   do_a1, do_a2;
    logic [IDX_W-1:0]       idx_1, idx_2;

    logic [LANES-1:0]               chain, ret_fire;
    logic [LANES-1:0][IDX_W-1:0]    ret_idx;
    logic [LANES-1:0][PREG_NUM-1:0] lane_mask;
    logic [PREG_NUM-1:0]            free_nxt;

    // occupancy and allocation slots; ready looks at pre-edge count only
    always_comb begin
        count = tail - head;
        idx_1 = tail[IDX_W-1:0];
        // a lone slot-2 instr takes the tail; otherwise slot 2 sits behind slot 1
        idx_2 = (rob.alloc_valid_2 && !rob.alloc_valid_1) ? tail[IDX_W-1:0]
                                                          : tail[IDX_W-1:0] + IDX_W'(1);
    end

    assign rob.rob_count   = count;
    assign rob.alloc_ready = (count <= READY_MAX);
    assign rob.alloc_idx_1 = idx_1;
    assign rob.alloc_idx_2 = idx_2;
    assign do_a1 = rob.alloc_ready & rob.alloc_valid_1;
    assign do_a2 = rob.alloc_ready & rob.alloc_valid_2;

    // retire lanes walk from head; each lane is gated by the one before it
    for (genvar l = 0; l < LANES; l++) begin : g_lane
        assign ret_idx[l] = head[IDX_W-1:0] + IDX_W'(l);
        if (l == 0) begin : g_first
            assign chain[l] = 1'b1;
        end else begin : g_next
            assign chain[l] = ret_fire[l-1];
        end
        rob_retire_lane #(.PREG_NUM(PREG_NUM), .PTAG_W(PTAG_W)) u_lane (
            .prev_fire  (chain[l]),
            .ent_valid  (ent_valid[ret_idx[l]]),
            .ent_done   (ent_done[ret_idx[l]]),
            .ent_has_rd (ent_has_rd[ret_idx[l]]),
            .ent_oldrd  (ent_oldrd[ret_idx[l]]),
            .fire       (ret_fire[l]),
            .mask       (lane_mask[l])
        );
    end

    // next pointers and merged free mask
    always_comb begin
        head_nxt = head;
        free_nxt = '0;
        for (int l = 0; l < LANES; l++) begin
            if (ret_fire[l]) head_nxt = head_nxt + (IDX_W+1)'(1);
            free_nxt = free_nxt | lane_mask[l];
        end
        tail_nxt = tail + (IDX_W+1)'(do_a1) + (IDX_W+1)'(do_a2);
    end

    // control state: completes, then retire clears, then new allocations
    always_ff @(posedge clk) begin
        if (reset) begin
            head               <= '0;
            tail               <= '0;
            ent_valid          <= '0;
            ent_done           <= '0;
            rob.retire_valid_1 <= 1'b0;
            rob.retire_newrd_1 <= '0;
            rob.retire_valid_2 <= 1'b0;
            rob.retire_newrd_2 <= '0;
            rob.free_regs      <= '0;
        end else begin
            head <= head_nxt;
            tail <= tail_nxt;
            if (rob.complete_valid_a && ent_valid[rob.complete_idx_a])
                ent_done[rob.complete_idx_a] <= 1'b1;
            if (rob.complete_valid_b && ent_valid[rob.complete_idx_b])
                ent_done[rob.complete_idx_b] <= 1'b1;
            for (int l = 0; l < LANES; l++) begin
                if (ret_fire[l]) begin
                    ent_valid[ret_idx[l]] <= 1'b0;
                    ent_done[ret_idx[l]]  <= 1'b0;
                end
            end
            if (do_a1) begin
                ent_valid[idx_1] <= 1'b1;
                ent_done[idx_1]  <= 1'b0;
            end
            if (do_a2) begin
                ent_valid[idx_2] <= 1'b1;
                ent_done[idx_2]  <= 1'b0;
            end
            rob.retire_valid_1 <= ret_fire[0];
            rob.retire_newrd_1 <= ret_fire[0] ? ent_newrd[ret_idx[0]] : '0;
            rob.retire_valid_2 <= ret_fire[1];
            rob.retire_newrd_2 <= ret_fire[1] ? ent_newrd[ret_idx[1]] : '0;
            rob.free_regs      <= free_nxt;
        end
    end

    // entry payload; only meaningful while valid, so no reset needed
    always_ff @(posedge clk) begin
        if (do_a1) begin
            ent_has_rd[idx_1] <= rob.alloc_has_rd_1;
            ent_newrd[idx_1]  <= rob.alloc_newrd_1;
            ent_oldrd[idx_1]  <= rob.alloc_oldrd_1;
        end
        if (do_a2) begin
            ent_has_rd[idx_2] <= rob.alloc_has_rd_2;
            ent_newrd[idx_2]  <= rob.alloc_newrd_2;
            ent_oldrd[idx_2]  <= rob.alloc_oldrd_2;
        end
    end
endmodule

// File: tb/tb_rob_retire.sv
// Bench for rob_retire: program-order queue model, directed scenarios and a random wrap run.
module tb_rob_retire;
    localparam int DEPTH = 16;
    localparam int PREG  = 64;
    localparam int PW    = 6;
    localparam int IW    = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    rob_retire_if #(.PREG_NUM(PREG), .PTAG_W(PW), .IDX_W(IW)) bus();
    rob_retire #(.ROB_DEPTH(DEPTH), .PREG_NUM(PREG), .PTAG_W(PW), .IDX_W(IW)) dut (
        .clk   (clk),
        .reset (reset),
        .rob   (bus)
    );

    typedef struct {
        bit          has_rd;
        bit [PW-1:0] newrd;
        bit [PW-1:0] oldrd;
        bit          done;
        bit [IW-1:0] idx;
    } ent_t;

    ent_t        mq[$];      // in-flight instrs, oldest first
    bit [IW-1:0] next_idx;
    int          n_checks = 0;
    int          n_fail = 0;

    logic          obs_ready, exp_ready;
    logic [IW-1:0] obs_idx1, obs_idx2, exp_idx1, exp_idx2;
    logic [IW:0]   obs_cnt, exp_cnt;
    logic          obs_rv1, obs_rv2, exp_rv1, exp_rv2;
    logic [PW-1:0] obs_nr1, obs_nr2, exp_nr1, exp_nr2;
    logic [PREG-1:0] obs_free, exp_free;

    task automatic clear_inputs();
        bus.alloc_valid_1 = 0; bus.alloc_has_rd_1 = 0; bus.alloc_newrd_1 = 0; bus.alloc_oldrd_1 = 0;
        bus.alloc_valid_2 = 0; bus.alloc_has_rd_2 = 0; bus.alloc_newrd_2 = 0; bus.alloc_oldrd_2 = 0;
        bus.complete_valid_a = 0; bus.complete_idx_a = 0;
        bus.complete_valid_b = 0; bus.complete_idx_b = 0;
    endtask

    task automatic set_alloc1(input bit h, input bit [PW-1:0] n, input bit [PW-1:0] o);
        bus.alloc_valid_1 = 1; bus.alloc_has_rd_1 = h; bus.alloc_newrd_1 = n; bus.alloc_oldrd_1 = o;
    endtask

    task automatic set_alloc2(input bit h, input bit [PW-1:0] n, input bit [PW-1:0] o);
        bus.alloc_valid_2 = 1; bus.alloc_has_rd_2 = h; bus.alloc_newrd_2 = n; bus.alloc_oldrd_2 = o;
    endtask

    task automatic set_comp(input bit a_v, input bit [IW-1:0] a_i, input bit b_v, input bit [IW-1:0] b_i);
        bus.complete_valid_a = a_v; bus.complete_idx_a = a_i;
        bus.complete_valid_b = b_v; bus.complete_idx_b = b_i;
    endtask

    function automatic bit [PREG-1:0] free_of(input ent_t e);
        bit [PREG-1:0] m;
        m = '0;
        if (e.has_rd && e.oldrd != 0) m[e.oldrd] = 1'b1;
        return m;
    endfunction

    // one clock: sample comb outputs, advance the model, sample registered outputs
    task automatic tick();
        ent_t e;
        bit   r1, r2;
        #1;
        obs_ready = bus.alloc_ready; obs_idx1 = bus.alloc_idx_1;
        obs_idx2  = bus.alloc_idx_2; obs_cnt  = bus.rob_count;
        exp_cnt   = (IW+1)'(mq.size());
        exp_ready = (mq.size() <= DEPTH - 2);
        exp_idx1  = next_idx;
        exp_idx2  = (bus.alloc_valid_2 && !bus.alloc_valid_1) ? next_idx : next_idx + 4'd1;
        r1 = (mq.size() > 0) && mq[0].done;
        r2 = r1 && (mq.size() > 1) && mq[1].done;
        exp_rv1 = r1; exp_rv2 = r2;
        exp_nr1 = r1 ? mq[0].newrd : '0;
        exp_nr2 = r2 ? mq[1].newrd : '0;
        exp_free = (r1 ? free_of(mq[0]) : '0) | (r2 ? free_of(mq[1]) : '0);
        if (r1) void'(mq.pop_front());
        if (r2) void'(mq.pop_front());
        foreach (mq[k]) begin
            if (bus.complete_valid_a && mq[k].idx == bus.complete_idx_a) mq[k].done = 1;
            if (bus.complete_valid_b && mq[k].idx == bus.complete_idx_b) mq[k].done = 1;
        end
        if (exp_ready && bus.alloc_valid_1) begin
            e.has_rd = bus.alloc_has_rd_1; e.newrd = bus.alloc_newrd_1; e.oldrd = bus.alloc_oldrd_1;
            e.done = 0; e.idx = next_idx; mq.push_back(e); next_idx = next_idx + 4'd1;
        end
        if (exp_ready && bus.alloc_valid_2) begin
            e.has_rd = bus.alloc_has_rd_2; e.newrd = bus.alloc_newrd_2; e.oldrd = bus.alloc_oldrd_2;
            e.done = 0; e.idx = next_idx; mq.push_back(e); next_idx = next_idx + 4'd1;
        end
        @(posedge clk); #1;
        obs_rv1 = bus.retire_valid_1; obs_nr1 = bus.retire_newrd_1;
        obs_rv2 = bus.retire_valid_2; obs_nr2 = bus.retire_newrd_2;
        obs_free = bus.free_regs;
        clear_inputs();
    endtask

    // reset for one edge with an alloc presented; the alloc must be dropped
    task automatic do_reset();
        clear_inputs();
        set_alloc1(1, 6'd9, 6'd9);
        reset = 1;
        @(posedge clk); #1;
        reset = 0;
        clear_inputs();
        mq.delete();
        next_idx = 0;
        obs_rv1 = bus.retire_valid_1; obs_nr1 = bus.retire_newrd_1;
        obs_rv2 = bus.retire_valid_2; obs_nr2 = bus.retire_newrd_2;
        obs_free = bus.free_regs;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (bus.rob_count !== 5'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", bus.rob_count); end
        n_checks++;
        if (bus.alloc_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %0b want 1", bus.alloc_ready); end
        n_checks++;
        if ({obs_rv1, obs_rv2, obs_nr1, obs_nr2} !== '0) begin
            n_fail++; $display("FAIL reset_retire: got rv=%0b%0b nr=%0d/%0d want 0", obs_rv1, obs_rv2, obs_nr1, obs_nr2);
        end
        n_checks++;
        if (obs_free !== '0) begin n_fail++; $display("FAIL reset_free: got %h want 0", obs_free); end
        n_checks++;
        if (bus.alloc_idx_1 !== 4'd0) begin n_fail++; $display("FAIL reset_idx1: got %0d want 0", bus.alloc_idx_1); end
    endtask

    task automatic test_single();
        do_reset();
        set_alloc1(1, 6'd32, 6'd5);
        tick();
        n_checks++;
        if (obs_idx1 !== 4'd0 || obs_idx2 !== 4'd1) begin
            n_fail++; $display("FAIL single_idx: got %0d/%0d want 0/1", obs_idx1, obs_idx2);
        end
        set_comp(1, 4'd0, 0, 4'd0);
        tick();
        n_checks++;
        if (obs_rv1 !== 1'b0 || obs_free !== '0) begin
            n_fail++; $display("FAIL single_early: got rv1=%0b free=%h want no retire", obs_rv1, obs_free);
        end
        tick();
        n_checks++;
        if (obs_rv1 !== 1'b1 || obs_nr1 !== 6'd32 || obs_rv2 !== 1'b0 || obs_free !== (64'd1 << 5)) begin
            n_fail++; $display("FAIL single_retire: got rv=%0b%0b nr1=%0d free=%h want rv=10 nr1=32 free=%h",
                               obs_rv1, obs_rv2, obs_nr1, obs_free, 64'd1 << 5);
        end
        tick();
        n_checks++;
        if (obs_rv1 !== 1'b0 || obs_free !== '0 || obs_cnt !== 5'd0) begin
            n_fail++; $display("FAIL single_pulse: got rv1=%0b free=%h cnt=%0d want 0/0/0", obs_rv1, obs_free, obs_cnt);
        end
    endtask

    task automatic test_pair();
        do_reset();
        set_alloc1(1, 6'd40, 6'd3);
        set_alloc2(1, 6'd41, 6'd7);
        tick();
        set_comp(1, 4'd1, 0, 4'd0);
        tick();
        tick();
        n_checks++;
        if (obs_rv1 !== 1'b0 || obs_rv2 !== 1'b0 || obs_cnt !== 5'd2) begin
            n_fail++; $display("FAIL pair_blocked: got rv=%0b%0b cnt=%0d want rv=00 cnt=2", obs_rv1, obs_rv2, obs_cnt);
        end
        set_comp(0, 4'd0, 1, 4'd0);
        tick();
        tick();
        n_checks++;
        if ({obs_rv1, obs_rv2, obs_nr1, obs_nr2} !== {1'b1, 1'b1, 6'd40, 6'd41} ||
            obs_free !== ((64'd1 << 3) | (64'd1 << 7))) begin
            n_fail++; $display("FAIL pair_retire: got rv=%0b%0b nr=%0d/%0d free=%h want rv=11 nr=40/41 free=88",
                               obs_rv1, obs_rv2, obs_nr1, obs_nr2, obs_free);
        end
    endtask

    task automatic test_no_free();
        do_reset();
        set_alloc1(0, 6'd20, 6'd9);
        set_alloc2(1, 6'd21, 6'd0);
        tick();
        set_comp(1, 4'd0, 1, 4'd1);
        tick();
        tick();
        n_checks++;
        if (obs_rv1 !== 1'b1 || obs_rv2 !== 1'b1 || obs_free !== '0) begin
            n_fail++; $display("FAIL nofree: got rv=%0b%0b free=%h want rv=11 free=0", obs_rv1, obs_rv2, obs_free);
        end
        set_alloc1(1, 6'd22, 6'd12);
        tick();
        set_comp(1, 4'd2, 1, 4'd2);
        tick();
        tick();
        n_checks++;
        if (obs_rv1 !== 1'b1 || obs_rv2 !== 1'b0 || obs_nr1 !== 6'd22 || obs_free !== (64'd1 << 12)) begin
            n_fail++; $display("FAIL same_idx: got rv=%0b%0b nr1=%0d free=%h want rv=10 nr1=22 free=%h",
                               obs_rv1, obs_rv2, obs_nr1, obs_free, 64'd1 << 12);
        end
    endtask

    task automatic test_full();
        do_reset();
        for (int i = 0; i < DEPTH / 2; i++) begin
            set_alloc1(1, 6'(2 * i), 6'(2 * i + 1));
            set_alloc2(1, 6'(2 * i + 1), 6'(2 * i + 2));
            tick();
            n_checks++;
            if ({obs_ready, obs_idx1, obs_idx2, obs_cnt} !== {exp_ready, exp_idx1, exp_idx2, exp_cnt}) begin
                n_fail++; $display("FAIL fill_comb[%0d]: got rdy=%0b idx=%0d/%0d cnt=%0d want rdy=%0b idx=%0d/%0d cnt=%0d",
                                   i, obs_ready, obs_idx1, obs_idx2, obs_cnt, exp_ready, exp_idx1, exp_idx2, exp_cnt);
            end
        end
        set_alloc1(1, 6'd50, 6'd50);
        set_alloc2(1, 6'd51, 6'd51);
        tick();
        n_checks++;
        if (obs_ready !== 1'b0 || obs_cnt !== 5'd16) begin
            n_fail++; $display("FAIL full_state: got rdy=%0b cnt=%0d want rdy=0 cnt=16", obs_ready, obs_cnt);
        end
        set_comp(1, 4'd0, 1, 4'd1);
        set_alloc1(1, 6'd52, 6'd52);
        tick();
        set_alloc1(1, 6'd53, 6'd53);
        set_alloc2(1, 6'd54, 6'd54);
        tick();
        n_checks++;
        if (obs_ready !== 1'b0 || obs_rv1 !== 1'b1 || obs_rv2 !== 1'b1 || obs_nr1 !== 6'd0 || obs_nr2 !== 6'd1) begin
            n_fail++; $display("FAIL full_retire: got rdy=%0b rv=%0b%0b nr=%0d/%0d want rdy=0 rv=11 nr=0/1",
                               obs_ready, obs_rv1, obs_rv2, obs_nr1, obs_nr2);
        end
        tick();
        n_checks++;
        if (obs_ready !== 1'b1 || obs_cnt !== 5'd14) begin
            n_fail++; $display("FAIL full_reopen: got rdy=%0b cnt=%0d want rdy=1 cnt=14", obs_ready, obs_cnt);
        end
    endtask

    task automatic test_random_wrap();
        int          tag = 0;
        int          dut_ret = 0;
        int          mdl_ret = 0;
        bit [1:0]    r;
        bit [IW-1:0] ia, ib;
        do_reset();
        for (int cyc = 0; cyc < 320; cyc++) begin
            r = 2'($urandom_range(0, 3));
            if (cyc < 260 && r[0]) begin set_alloc1(1'($urandom), 6'(tag), 6'($urandom_range(0, 63))); tag++; end
            if (cyc < 260 && r[1]) begin set_alloc2(1'($urandom), 6'(tag), 6'($urandom_range(0, 63))); tag++; end
            ia = 4'($urandom); ib = 4'($urandom);
            if (mq.size() > 0) begin
                ia = mq[$urandom_range(0, mq.size() - 1)].idx;
                ib = ($urandom_range(0, 4) == 0) ? ia : mq[$urandom_range(0, mq.size() - 1)].idx;
            end
            set_comp($urandom_range(0, 2) != 0, ia, $urandom_range(0, 2) == 0, ib);
            tick();
            mdl_ret += int'(exp_rv1) + int'(exp_rv2);
            dut_ret += int'(obs_rv1 === 1'b1) + int'(obs_rv2 === 1'b1);
            n_checks++;
            if ({obs_ready, obs_idx1, obs_idx2, obs_cnt} !== {exp_ready, exp_idx1, exp_idx2, exp_cnt}) begin
                n_fail++; $display("FAIL rand_comb[%0d]: got rdy=%0b idx=%0d/%0d cnt=%0d want rdy=%0b idx=%0d/%0d cnt=%0d",
                                   cyc, obs_ready, obs_idx1, obs_idx2, obs_cnt, exp_ready, exp_idx1, exp_idx2, exp_cnt);
            end
            n_checks++;
            if ({obs_rv1, obs_rv2, obs_nr1, obs_nr2, obs_free} !== {exp_rv1, exp_rv2, exp_nr1, exp_nr2, exp_free}) begin
                n_fail++; $display("FAIL rand_retire[%0d]: got rv=%0b%0b nr=%0d/%0d free=%h want rv=%0b%0b nr=%0d/%0d free=%h",
                                   cyc, obs_rv1, obs_rv2, obs_nr1, obs_nr2, obs_free,
                                   exp_rv1, exp_rv2, exp_nr1, exp_nr2, exp_free);
            end
            n_checks++;
            if (obs_cnt > 5'd16) begin n_fail++; $display("FAIL rand_overflow[%0d]: got cnt=%0d want <=16", cyc, obs_cnt); end
        end
        n_checks++;
        if (dut_ret != mdl_ret || dut_ret < 40) begin
            n_fail++; $display("FAIL rand_total: got %0d retires want %0d (>=40)", dut_ret, mdl_ret);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            set_alloc1(1, 6'(10 + 2 * i), 6'(20 + 2 * i));
            set_alloc2(1, 6'(11 + 2 * i), 6'(21 + 2 * i));
            tick();
        end
        set_comp(1, 4'd1, 1, 4'd2);
        tick();
        set_comp(1, 4'd0, 0, 4'd0);
        tick();
        n_checks++;
        if (obs_cnt !== 5'd8) begin n_fail++; $display("FAIL mid_inflight: got cnt=%0d want 8", obs_cnt); end
        do_reset();
        n_checks++;
        if (obs_rv1 !== 1'b0 || obs_rv2 !== 1'b0 || obs_free !== '0 || bus.rob_count !== 5'd0) begin
            n_fail++; $display("FAIL mid_reset: got rv=%0b%0b free=%h cnt=%0d want all 0",
                               obs_rv1, obs_rv2, obs_free, bus.rob_count);
        end
        tick();
        n_checks++;
        if (obs_rv1 !== 1'b0 || obs_rv2 !== 1'b0 || obs_free !== '0) begin
            n_fail++; $display("FAIL mid_after: got rv=%0b%0b free=%h want no pulse", obs_rv1, obs_rv2, obs_free);
        end
        set_alloc1(1, 6'd60, 6'd61);
        tick();
        n_checks++;
        if (obs_idx1 !== 4'd0 || obs_cnt !== 5'd0) begin
            n_fail++; $display("FAIL mid_realloc: got idx1=%0d cnt=%0d want 0/0", obs_idx1, obs_cnt);
        end
    endtask

    initial begin
        clear_inputs();
        next_idx = 0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_single();
        test_pair();
        test_no_free();
        test_full();
        test_random_wrap();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
